spi_matrix_master: RTL and testbench
====================================

# spi_matrix_master

Host-side SPI initiator that drives the transformer accelerator's SPI slave port. It generates `spi_cs_n`, `spi_sclk` and `spi_mosi` from `sys_clk` and samples `spi_miso`. Each transaction moves a burst of 16-bit words: either matrix data into accelerator memory, or results read back out of it. The block sits in the system clock domain of the test/host FPGA and faces the accelerator's SPI pins.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `sys_clk` cycles; legal values ≥2.
- `WORD_W`, 16: SPI frame width in bits; fixed at 16 for this protocol.
- `CNT_W`, 12: width of the word-count field.
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: reset; synchronous, active-low.
- `start` in 1: one-cycle request; accepted only when `busy`=0.
- `rd` in 1: latched with `start`; 0 = write burst, 1 = read burst.
- `word_count` in 12: latched with `start`; number of data words N.
- `tx_data` in 16: write data word.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: word taken when `tx_valid && tx_ready`.
- `rx_data` out 16: received word.
- `rx_valid` out 1: one-cycle pulse; there is no backpressure.
- `loopback` in 1: internal loopback select; active only with `SPI_MASTER_LOOPBACK_EN`.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle pulse when a transaction completes.
- `spi_cs_n` out 1: chip select, active-low.
- `spi_sclk` out 1: SPI clock, mode 0 (idle low).
- `spi_mosi` out 1: serial data to the slave.
- `spi_miso` in 1: serial data from the slave.

## Operation
- Reset values: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `busy`=0, `done`=0.
- Bus format: mode 0, MSB first.
- Slave timing: the slave samples MOSI on the SCLK rise and updates MISO on the SCLK fall.
- Frame 0 is the command word `{rd, 3'b000, word_count}`.
- Frames 1..N are data frames.
- Write burst: each data frame is loaded from `tx_data`.
- Read burst: MOSI sends 0x0000 during data frames and each received word is emitted on `rx_data`.
- MISO is also shifted in during the command frame, but that word is discarded.
- FSM states: IDLE, CS_SETUP, LOAD, SHIFT, CS_HOLD.
  - IDLE: on `start` with N≠0, latch `rd` and `word_count`, then go to CS_SETUP.
  - IDLE: on `start` with N=0, pulse `done` the next cycle with no bus activity.
  - CS_SETUP: `cs_n`=0 and `mosi`=cmd[15]. Wait CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 32 divider ticks. Odd ticks raise SCLK and sample MISO; even ticks lower SCLK and drive the next MOSI bit.
  - SHIFT, after the 32nd tick: if frames remain, go to LOAD; otherwise go to CS_HOLD.
  - LOAD, write burst: assert `tx_ready` and wait for `tx_valid`. While waiting, hold SCLK low and `cs_n` low (stall).
  - LOAD, read burst: one cycle, no wait.
  - LOAD, on load: set `mosi`=word[15], wait CLK_DIV cycles, then go to SHIFT.
  - CS_HOLD: SCLK low; wait CLK_DIV cycles, then set `cs_n`=1, pulse `done`, and return to IDLE.
- `start` while `busy` is ignored and not queued.
- Reset mid-transaction: next edge returns all outputs to reset values. The burst is abandoned, with no `done` and no `rx_valid`.
- `word_count` up to 4095 is legal.
- `tx_data` is ignored during read bursts; `tx_ready` stays 0.

## Timing
- Divider: one tick every CLK_DIV `sys_clk` cycles. A frame is 32·CLK_DIV cycles, excluding CS_SETUP/LOAD.
- `start` accepted at edge 0:
  - `busy`=1 and `cs_n`=0 at edge 1.
  - First SCLK rise at edge 1+CLK_DIV.
- MISO is registered on the same `sys_clk` edge that drives SCLK high.
- `rx_valid` pulses one cycle after the 16th sample of each data frame.
- Write burst: the load edge is the cycle with `tx_valid && tx_ready`. `tx_ready` drops on the following edge.
- `done` and `cs_n` rising share the same edge, CLK_DIV cycles after the last SCLK fall. `busy` clears on that same edge.
- Minimum CS-high time between bursts is 1 cycle. A new `start` is accepted on the edge after `done`.

## Configuration
- `SPI_MASTER_LOOPBACK_EN` defined: when `loopback`=1, the sampler uses internal `spi_mosi` instead of `spi_miso`. The SPI pins still toggle normally.
- Undefined: the `loopback` port exists but is ignored, and `spi_miso` is always sampled.

## Test plan
- Write burst, CLK_DIV=2, N=2, `tx_data` 0xA5A5 then 0x1234 → slave model receives 0x0002, 0xA5A5, 0x1234; exactly 48 SCLK rises; one `done`.
- Read burst, N=3, slave returns 0xBEEF, 0x0001, 0x8000 → MOSI command 0x8003; three `rx_valid` pulses carrying those values in order; MOSI data frames are 0x0000.
- Write N=2 with `tx_valid` low for 40 cycles before word 2 → SCLK held low, `cs_n` stays 0, no extra edges; slave receives the correct word after the stall.
- `start` with N=0 → `done` on edge 1; `cs_n` never falls. Also, `start` pulsed mid-burst → ignored; no second transaction.
- `sys_rst_n` low mid-frame of a 4-word write → next edge `cs_n`=1, `sclk`=0, no `done`; a following 1-word write completes correctly.
- With `SPI_MASTER_LOOPBACK_EN` defined, `loopback`=1, and a read burst N=1 → `rx_data`=0x0000, since MOSI sends zeros. Repeat with a modified bench forcing the write path: the word received equals the word sent.

Source files
------------

// File: rtl/spi_matrix_master.sv
// SPI mode-0 burst initiator: one command frame {rd,3'b000,count} then N 16-bit data frames.
// Optional internal MOSI->MISO loopback when SPI_MASTER_LOOPBACK_EN is defined.
module spi_matrix_master #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 16,
  parameter int CNT_W   = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              rd,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              loopback,
  output logic              busy,
  output logic              done,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, SHIFT, CS_HOLD} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [4:0]        tick_q;
  logic              rd_q;
  logic [CNT_W-1:0]  left_q;
  logic              data_frame_q;
  logic              loaded_q;
  logic              rx_pend_q;
  logic [WORD_W-1:0] tx_sh_q;
  logic [WORD_W-1:0] rx_sh_q;
  logic              tx_ready_q;
  logic [WORD_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              cs_n_q;
  logic              sclk_q;
  logic              mosi_q;

  logic              div_tick_s;
  logic              sin_s;
  logic [WORD_W-1:0] cmd_s;
  logic [WORD_W-1:0] load_word_s;

  assign div_tick_s  = (div_q == DIV_LAST);
  assign cmd_s       = {rd, {(WORD_W-1-CNT_W){1'b0}}, word_count};
  assign load_word_s = rd_q ? {WORD_W{1'b0}} : tx_data;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign sin_s = loopback ? mosi_q : spi_miso;
`else
  logic unused_loopback_s;
  assign unused_loopback_s = loopback;
  assign sin_s = spi_miso;
`endif

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;

  // Transaction FSM, SCLK divider, shift registers and all registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      div_q        <= {DIV_W{1'b0}};
      tick_q       <= 5'd0;
      rd_q         <= 1'b0;
      left_q       <= {CNT_W{1'b0}};
      data_frame_q <= 1'b0;
      loaded_q     <= 1'b0;
      rx_pend_q    <= 1'b0;
      tx_sh_q      <= {WORD_W{1'b0}};
      rx_sh_q      <= {WORD_W{1'b0}};
      tx_ready_q   <= 1'b0;
      rx_data_q    <= {WORD_W{1'b0}};
      rx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      // A full word was sampled on the previous edge; publish it now.
      if (rx_pend_q) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= rx_sh_q;
        rx_pend_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          div_q <= {DIV_W{1'b0}};
          if (start) begin
            if (word_count == {CNT_W{1'b0}}) begin
              done_q <= 1'b1;
            end else begin
              state_q      <= CS_SETUP;
              busy_q       <= 1'b1;
              cs_n_q       <= 1'b0;
              rd_q         <= rd;
              left_q       <= word_count;
              data_frame_q <= 1'b0;
              mosi_q       <= cmd_s[WORD_W-1];
              tx_sh_q      <= {cmd_s[WORD_W-2:0], 1'b0};
            end
          end
        end
        CS_SETUP: begin
          if (div_tick_s) begin
            state_q <= SHIFT;
            div_q   <= {DIV_W{1'b0}};
            tick_q  <= 5'd1;
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[WORD_W-2:0], sin_s};
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (div_tick_s) begin
            div_q  <= {DIV_W{1'b0}};
            tick_q <= tick_q + 5'd1;
            if (!tick_q[0]) begin
              sclk_q  <= 1'b1;
              rx_sh_q <= {rx_sh_q[WORD_W-2:0], sin_s};
              if (tick_q == 5'd30 && data_frame_q && rd_q) begin
                rx_pend_q <= 1'b1;
              end
            end else begin
              sclk_q  <= 1'b0;
              mosi_q  <= tx_sh_q[WORD_W-1];
              tx_sh_q <= {tx_sh_q[WORD_W-2:0], 1'b0};
              if (tick_q == 5'd31) begin
                if (left_q != {CNT_W{1'b0}}) begin
                  state_q    <= LOAD;
                  loaded_q   <= 1'b0;
                  tx_ready_q <= !rd_q;
                end else begin
                  state_q <= CS_HOLD;
                end
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        LOAD: begin
          // Write bursts stall here with SCLK low until the host offers a word.
          if (!loaded_q) begin
            if (rd_q || (tx_valid && tx_ready_q)) begin
              loaded_q     <= 1'b1;
              tx_ready_q   <= 1'b0;
              left_q       <= left_q - CNT_W'(1);
              data_frame_q <= 1'b1;
              div_q        <= {DIV_W{1'b0}};
              mosi_q       <= load_word_s[WORD_W-1];
              tx_sh_q      <= {load_word_s[WORD_W-2:0], 1'b0};
            end
          end else if (div_tick_s) begin
            state_q <= SHIFT;
            div_q   <= {DIV_W{1'b0}};
            tick_q  <= 5'd1;
            sclk_q  <= 1'b1;
            rx_sh_q <= {rx_sh_q[WORD_W-2:0], sin_s};
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        CS_HOLD: begin
          sclk_q <= 1'b0;
          if (div_tick_s) begin
            state_q <= IDLE;
            div_q   <= {DIV_W{1'b0}};
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_matrix_master.sv
// Directed self-checking bench for spi_matrix_master with a mode-0 SPI slave model.
module tb_spi_matrix_master;

  localparam int CLK_DIV = 2;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic        rd;
  logic [11:0] word_count;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        loopback;
  logic        busy;
  logic        done;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  int checks;
  int errors;

  spi_matrix_master #(.CLK_DIV(CLK_DIV), .WORD_W(16), .CNT_W(12)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .rd(rd),
    .word_count(word_count), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .loopback(loopback), .busy(busy), .done(done), .spi_cs_n(spi_cs_n),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  // Slave model and output monitors, sampled on the falling system clock edge.
  logic        prev_cs;
  logic        prev_sclk;
  logic [15:0] sl_sh;
  int          sl_bits;
  int          sl_frame;
  int          sclk_rises;
  int          cs_falls;
  int          done_cnt;
  int          ready_seen;
  logic [15:0] slave_rx[$];
  logic [15:0] rxq[$];
  logic [15:0] resp [0:7];

  always @(negedge sys_clk) begin
    if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
      cs_falls++;
      sl_bits  = 0;
      sl_frame = 0;
      spi_miso = resp[0][15];
    end else if (prev_sclk === 1'b0 && spi_sclk === 1'b1) begin
      sclk_rises++;
      sl_sh = {sl_sh[14:0], spi_mosi};
      sl_bits++;
      if (sl_bits == 16) begin
        slave_rx.push_back(sl_sh);
        sl_bits  = 0;
        sl_frame = (sl_frame + 1) % 8;
      end
    end else if (prev_sclk === 1'b1 && spi_sclk === 1'b0 && spi_cs_n === 1'b0) begin
      spi_miso = resp[sl_frame][15 - sl_bits];
    end
    if (rx_valid === 1'b1) rxq.push_back(rx_data);
    if (done === 1'b1) done_cnt++;
    if (tx_ready === 1'b1) ready_seen++;
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start(input logic r, input logic [11:0] n);
    @(posedge sys_clk);
    #1;
    start = 1'b1; rd = r; word_count = n;
    @(posedge sys_clk);
    #1;
    start = 1'b0; rd = 1'b0; word_count = 12'd0;
  endtask

  task automatic send_word(input logic [15:0] w, input int stall);
    int k;
    int bad;
    int base_r;
    k = 0;
    while (tx_ready !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_wait got %b want 1", tx_ready);
    end
    if (stall > 0) begin
      bad = 0;
      base_r = sclk_rises;
      repeat (stall) begin
        tick(1);
        if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0 || sclk_rises != base_r) begin
        errors++;
        $display("FAIL stall_hold got bad=%0d rises=%0d want bad=0 rises=%0d", bad, sclk_rises, base_r);
      end
    end
    tx_data = w; tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_drop got %b want 0", tx_ready);
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got %b want 1", done);
    end else begin
      checks++;
      if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_edge got cs_n=%b busy=%b want cs_n=1 busy=0", spi_cs_n, busy);
      end
      tick(1);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got %b want 0", done);
      end
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    tick(3);
    checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi, tx_ready, rx_valid, busy, done} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000000",
               {spi_cs_n, spi_sclk, spi_mosi, tx_ready, rx_valid, busy, done});
    end
    checks++;
    if (rx_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rx_data got %h want 0000", rx_data);
    end
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_write;
    int bs;
    int br;
    int bd;
    bs = slave_rx.size(); br = sclk_rises; bd = done_cnt;
    pulse_start(1'b0, 12'd2);
    checks++;
    if (busy !== 1'b1 || spi_cs_n !== 1'b0 || spi_sclk !== 1'b0) begin
      errors++;
      $display("FAIL start_edge1 got busy=%b cs_n=%b sclk=%b want 1 0 0", busy, spi_cs_n, spi_sclk);
    end
    tick(CLK_DIV - 1);
    checks++;
    if (spi_sclk !== 1'b0) begin
      errors++;
      $display("FAIL sclk_early got %b want 0", spi_sclk);
    end
    tick(1);
    checks++;
    if (spi_sclk !== 1'b1) begin
      errors++;
      $display("FAIL first_rise got %b want 1", spi_sclk);
    end
    send_word(16'hA5A5, 0);
    send_word(16'h1234, 0);
    wait_done(1000);
    checks++;
    if (slave_rx.size() - bs != 3) begin
      errors++;
      $display("FAIL wr_frames got %0d want 3", slave_rx.size() - bs);
    end else begin
      checks++;
      if (slave_rx[bs] !== 16'h0002 || slave_rx[bs+1] !== 16'hA5A5 || slave_rx[bs+2] !== 16'h1234) begin
        errors++;
        $display("FAIL wr_words got %h %h %h want 0002 a5a5 1234", slave_rx[bs], slave_rx[bs+1], slave_rx[bs+2]);
      end
    end
    checks++;
    if (sclk_rises - br != 48) begin
      errors++;
      $display("FAIL wr_rises got %0d want 48", sclk_rises - br);
    end
    checks++;
    if (done_cnt - bd != 1) begin
      errors++;
      $display("FAIL wr_done_count got %0d want 1", done_cnt - bd);
    end
  endtask

  task automatic test_read;
    int bs;
    int bq;
    int brd;
    resp[0] = 16'h5A5A; resp[1] = 16'hBEEF; resp[2] = 16'h0001; resp[3] = 16'h8000;
    bs = slave_rx.size(); bq = rxq.size(); brd = ready_seen;
    tx_data = 16'hFFFF;
    pulse_start(1'b1, 12'd3);
    wait_done(1000);
    checks++;
    if (slave_rx.size() - bs != 4) begin
      errors++;
      $display("FAIL rd_frames got %0d want 4", slave_rx.size() - bs);
    end else begin
      checks++;
      if (slave_rx[bs] !== 16'h8003) begin
        errors++;
        $display("FAIL rd_cmd got %h want 8003", slave_rx[bs]);
      end
      checks++;
      if ((slave_rx[bs+1] | slave_rx[bs+2] | slave_rx[bs+3]) !== 16'h0000) begin
        errors++;
        $display("FAIL rd_mosi_zero got %h %h %h want 0000", slave_rx[bs+1], slave_rx[bs+2], slave_rx[bs+3]);
      end
    end
    checks++;
    if (rxq.size() - bq != 3) begin
      errors++;
      $display("FAIL rd_valid_count got %0d want 3", rxq.size() - bq);
    end else begin
      checks++;
      if (rxq[bq] !== 16'hBEEF || rxq[bq+1] !== 16'h0001 || rxq[bq+2] !== 16'h8000) begin
        errors++;
        $display("FAIL rd_data got %h %h %h want beef 0001 8000", rxq[bq], rxq[bq+1], rxq[bq+2]);
      end
    end
    checks++;
    if (ready_seen != brd) begin
      errors++;
      $display("FAIL rd_tx_ready got %0d want 0", ready_seen - brd);
    end
  endtask

  task automatic test_stall;
    int bs;
    int br;
    bs = slave_rx.size(); br = sclk_rises;
    pulse_start(1'b0, 12'd2);
    send_word(16'h0F0F, 0);
    send_word(16'hF00D, 40);
    wait_done(1000);
    checks++;
    if (slave_rx.size() - bs != 3) begin
      errors++;
      $display("FAIL st_frames got %0d want 3", slave_rx.size() - bs);
    end else begin
      checks++;
      if (slave_rx[bs] !== 16'h0002 || slave_rx[bs+1] !== 16'h0F0F || slave_rx[bs+2] !== 16'hF00D) begin
        errors++;
        $display("FAIL st_words got %h %h %h want 0002 0f0f f00d", slave_rx[bs], slave_rx[bs+1], slave_rx[bs+2]);
      end
    end
    checks++;
    if (sclk_rises - br != 48) begin
      errors++;
      $display("FAIL st_rises got %0d want 48", sclk_rises - br);
    end
  endtask

  task automatic test_zero_and_busy;
    int bc;
    int bd;
    int bs;
    bc = cs_falls;
    pulse_start(1'b0, 12'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b cs_n=%b want 1 0 1", done, busy, spi_cs_n);
    end
    tick(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got %b want 0", done);
    end
    tick(5);
    checks++;
    if (cs_falls != bc) begin
      errors++;
      $display("FAIL zero_cs got %0d want 0", cs_falls - bc);
    end
    bc = cs_falls; bd = done_cnt; bs = slave_rx.size();
    pulse_start(1'b0, 12'd1);
    tick(10);
    pulse_start(1'b1, 12'd5);
    send_word(16'h3C3C, 0);
    wait_done(1000);
    tick(300);
    checks++;
    if (cs_falls - bc != 1 || done_cnt - bd != 1 || slave_rx.size() - bs != 2) begin
      errors++;
      $display("FAIL busy_ignore got cs=%0d done=%0d frames=%0d want 1 1 2",
               cs_falls - bc, done_cnt - bd, slave_rx.size() - bs);
    end else begin
      checks++;
      if (slave_rx[bs] !== 16'h0001 || slave_rx[bs+1] !== 16'h3C3C) begin
        errors++;
        $display("FAIL busy_words got %h %h want 0001 3c3c", slave_rx[bs], slave_rx[bs+1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int bd;
    int bq;
    int bs;
    bd = done_cnt; bq = rxq.size();
    pulse_start(1'b0, 12'd4);
    send_word(16'h1111, 0);
    tick(21);
    sys_rst_n = 1'b0;
    tick(1);
    checks++;
    if ({spi_cs_n, spi_sclk, spi_mosi, tx_ready, busy, done} !== 6'b100000) begin
      errors++;
      $display("FAIL mid_reset got %b want 100000", {spi_cs_n, spi_sclk, spi_mosi, tx_ready, busy, done});
    end
    tick(1);
    sys_rst_n = 1'b1;
    tick(100);
    checks++;
    if (done_cnt != bd || rxq.size() != bq) begin
      errors++;
      $display("FAIL mid_no_done got done=%0d rx=%0d want 0 0", done_cnt - bd, rxq.size() - bq);
    end
    bs = slave_rx.size();
    pulse_start(1'b0, 12'd1);
    send_word(16'hC3C3, 0);
    wait_done(1000);
    checks++;
    if (slave_rx.size() - bs != 2) begin
      errors++;
      $display("FAIL after_rst_frames got %0d want 2", slave_rx.size() - bs);
    end else begin
      checks++;
      if (slave_rx[bs] !== 16'h0001 || slave_rx[bs+1] !== 16'hC3C3) begin
        errors++;
        $display("FAIL after_rst_words got %h %h want 0001 c3c3", slave_rx[bs], slave_rx[bs+1]);
      end
    end
  endtask

`ifdef SPI_MASTER_LOOPBACK_EN
  task automatic test_loopback;
    int bq;
    resp[0] = 16'hFFFF; resp[1] = 16'hFFFF;
    bq = rxq.size();
    loopback = 1'b1;
    pulse_start(1'b1, 12'd1);
    wait_done(1000);
    loopback = 1'b0;
    checks++;
    if (rxq.size() - bq != 1) begin
      errors++;
      $display("FAIL lb_count got %0d want 1", rxq.size() - bq);
    end else begin
      checks++;
      if (rxq[bq] !== 16'h0000) begin
        errors++;
        $display("FAIL lb_data got %h want 0000", rxq[bq]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    sys_clk = 1'b0; sys_rst_n = 1'b0; start = 1'b0; rd = 1'b0;
    word_count = 12'd0; tx_data = 16'h0000; tx_valid = 1'b0; loopback = 1'b0;
    for (int i = 0; i < 8; i++) resp[i] = 16'h0000;
    test_reset;
    test_write;
    test_read;
    test_stall;
    test_zero_and_busy;
    test_reset_mid;
`ifdef SPI_MASTER_LOOPBACK_EN
    test_loopback;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
